// File: rtl/aes_selftest_seq_if.sv
// aes_selftest_seq_if: sequencer <-> aes_core control/data bundle.
interface aes_selftest_seq_if;
    logic         init;
    logic         next;
    logic [255:0] key;
    logic         keylen;
    logic [127:0] block;
    logic [127:0] result;
    logic         comp;
    logic         finished;
    modport master(output init, next, key, keylen, block, input result, comp, finished);
    modport slave(input init, next, key, keylen, block, output result, comp, finished);
endinterface

// File: rtl/aes_selftest_seq.sv
// aes_selftest_seq: key load plus LFSR-driven encipher/decipher self-check sequencer.
module aes_selftest_seq #(
    parameter int KEY_WAIT_CYCLES = 64,
    parameter int TIMEOUT_CYCLES  = 1023,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [255:0]       key_in,
    input  logic               keylen_in,
    input  logic [127:0]       seed,
    input  logic [CNT_W-1:0]   num_blocks,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   pass_count,
    output logic [CNT_W-1:0]   fail_count,
    output logic               timeout_err,
    output logic [127:0]       last_result,
    aes_selftest_seq_if.master core
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] KEY_INIT = 3'd1;
    localparam logic [2:0] ISSUE0   = 3'd2;
    localparam logic [2:0] ISSUE1   = 3'd3;
    localparam logic [2:0] WAIT     = 3'd4;
    localparam logic [2:0] CHECK    = 3'd5;
    localparam logic [2:0] FINISH   = 3'd6;
    localparam logic [127:0] TAPS    = 128'h2800_0005;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [2:0]       state;
    logic [7:0]       key_cnt;
    logic [CNT_W-1:0] blk_cnt;
    logic [15:0]      tmo_cnt;
    logic [127:0]     lfsr_next;

    // core.block doubles as the LFSR state
    always_comb lfsr_next = {core.block[126:0], 1'b0} ^ (core.block[127] ? TAPS : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
            timeout_err <= 1'b0;
            last_result <= '0;
            core.init   <= 1'b0;
            core.next   <= 1'b0;
            core.key    <= '0;
            core.keylen <= 1'b0;
            core.block  <= '0;
            key_cnt     <= '0;
            blk_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    core.key    <= key_in;
                    core.keylen <= keylen_in;
                    core.block  <= (seed == '0) ? 128'h1 : seed;
                    blk_cnt     <= num_blocks;
                    pass_count  <= '0;
                    fail_count  <= '0;
                    timeout_err <= 1'b0;
                    pass        <= 1'b0;
                    busy        <= 1'b1;
                    core.init   <= 1'b1;
                    key_cnt     <= 8'(KEY_WAIT_CYCLES - 1);
                    state       <= KEY_INIT;
                end
                KEY_INIT: if (key_cnt == '0) begin
                    core.init <= 1'b0;
                    if (blk_cnt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == '0) && !timeout_err;
                        state <= FINISH;
                    end else begin
                        core.next <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= ISSUE0;
                    end
                end else begin
                    key_cnt <= key_cnt - 8'd1;
                end
                ISSUE0: state <= ISSUE1;
                ISSUE1: begin
                    core.next <= 1'b0;
                    state     <= WAIT;
                end
                // finished takes priority over a coincident timeout
                WAIT: if (core.finished) begin
                    state <= CHECK;
                end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err <= 1'b1;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    pass        <= 1'b0;
                    state       <= FINISH;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
                CHECK: begin
                    if (core.comp) pass_count <= (pass_count == MAX) ? pass_count : pass_count + ONE;
                    else fail_count <= (fail_count == MAX) ? fail_count : fail_count + ONE;
                    last_result <= core.result;
                    blk_cnt     <= blk_cnt - ONE;
                    core.block  <= lfsr_next;
                    if (blk_cnt == ONE) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == '0) && core.comp && !timeout_err;
                        state <= FINISH;
                    end else begin
                        core.next <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= ISSUE0;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
